// File: rtl/pitch_pkg.sv
// Shared types and constants for the pitch period detector.
// Holds the FSM state enum, pipeline depth and datapath widths.
package pitch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SUM,
        ST_EVAL,
        ST_REPORT
    } state_t;

    localparam int PIPE     = 5;
    localparam int SAMPLE_W = 16;
    localparam int DIFF_W   = 17;
    localparam int SQ_W     = 34;
    localparam int D_W      = 44;
    localparam int S_W      = 56;
    localparam int PROD_W   = 64;
    localparam int TAU_W    = 11;

    localparam int WINDOW_SIZE_DEF = 2048;
    localparam int TAU_MAX_DEF     = 1023;

    // Number of difference terms summed per lag.
    function automatic int w_int(input int ws, input int tmax);
        return ws - tmax - 1;
    endfunction

    localparam int W_INT = w_int(WINDOW_SIZE_DEF, TAU_MAX_DEF);

endpackage

// File: rtl/sq_diff_accumulator.sv
// Pipelined (a-b)^2 accumulator: subtract, square, accumulate.
// start clears the sum; done pulses once the last term is in.
module sq_diff_accumulator
    import pitch_pkg::*;
(
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic                       in_last,
    input  logic signed [SAMPLE_W-1:0] x_a,
    input  logic signed [SAMPLE_W-1:0] x_b,
    output logic                       done,
    output logic [D_W-1:0]             d_sum
);

    logic signed [DIFF_W-1:0] diff_c;
    logic signed [SQ_W-1:0]   diff_x;
    logic signed [SQ_W-1:0]   sq_c;

    logic signed [DIFF_W-1:0] diff_q;
    logic                     diff_v_q;
    logic                     diff_l_q;
    logic [SQ_W-1:0]          sq_q;
    logic                     sq_v_q;
    logic                     sq_l_q;
    logic [D_W-1:0]           acc_q;
    logic                     done_q;

    always_comb begin
        diff_c = DIFF_W'(x_a) - DIFF_W'(x_b);
        diff_x = SQ_W'(diff_q);
        sq_c   = diff_x * diff_x;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            diff_q   <= '0;
            diff_v_q <= 1'b0;
            diff_l_q <= 1'b0;
            sq_q     <= '0;
            sq_v_q   <= 1'b0;
            sq_l_q   <= 1'b0;
            acc_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            diff_q   <= diff_c;
            diff_v_q <= in_valid;
            diff_l_q <= in_valid & in_last;
            sq_q     <= $unsigned(sq_c);
            sq_v_q   <= diff_v_q;
            sq_l_q   <= diff_l_q;
            if (start) begin
                acc_q <= '0;
            end else if (sq_v_q) begin
                acc_q <= acc_q + D_W'(sq_q);
            end
            done_q <= sq_v_q & sq_l_q;
        end
    end

    assign done  = done_q;
    assign d_sum = acc_q;

endmodule

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// Single-clock true dual-port RAM, read-first, with output register.
// Read latency is two cycles on both ports.
module xilinx_true_dual_port_read_first_1_clock_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
) (
    input  logic              clk_in,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    output logic [DATA_W-1:0] dout_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] dout_b
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] ra_q;
    logic [DATA_W-1:0] rb_q;

    always_ff @(posedge clk_in) begin
        if (we_a) mem[addr_a] <= din_a;
        if (we_b) mem[addr_b] <= din_b;
        ra_q   <= mem[addr_a];
        rb_q   <= mem[addr_b];
        dout_a <= ra_q;
        dout_b <= rb_q;
    end

endmodule

// File: rtl/pitch_period_detector.sv
// YIN-style pitch period detector over ping-pong sample windows.
// Evaluates lags 1..TAU_MAX until a normalized-difference dip is found.
module pitch_period_detector
    import pitch_pkg::*;
#(
    parameter int WINDOW_SIZE  = 2048,
    parameter int TAU_MIN      = 20,
    parameter int TAU_MAX      = 1023,
    parameter int THRESH_SHIFT = 3
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic signed [15:0] sample_in,
    input  logic              sample_valid_in,
    output logic [10:0]       tau_out,
    output logic              tau_valid_out,
    output logic              no_pitch_out,
    output logic              overrun_out,
    output logic              busy_out
);

    localparam int AW = $clog2(WINDOW_SIZE);
    localparam int WI = w_int(WINDOW_SIZE, TAU_MAX);
    localparam logic [AW-1:0]    LAST_IDX = AW'(WINDOW_SIZE - 1);
    localparam logic [AW-1:0]    WI_CNT   = AW'(WI);
    localparam logic [TAU_W-1:0] TMIN     = TAU_W'(TAU_MIN);
    localparam logic [TAU_W-1:0] TMAX     = TAU_W'(TAU_MAX);

    state_t state_q, state_d;

    logic [AW-1:0]    wr_idx_q;
    logic             bank_q;
    logic             ovr_q;
    logic [AW-1:0]    iss_cnt_q;
    logic             v_d1_q, v_d2_q, l_d1_q, l_d2_q;
    logic [TAU_W-1:0] tau_q;
    logic [TAU_W-1:0] tau_out_q;
    logic [S_W-1:0]   s_q;
    logic [D_W-1:0]   d_prev_q;
    logic             desc_q;
    logic             found_q;

    logic             win_end, busy, go;
    logic             iss_active, iss_last;
    logic [AW:0]      wr_addr, rd_addr_n, rd_addr_t;
    logic [SAMPLE_W-1:0] x_n, x_t;
    logic [SAMPLE_W-1:0] ram_n_unused, ram_t_unused;
    logic             acc_done;
    logic [D_W-1:0]   d_cur;
    logic [S_W-1:0]   s_new;
    logic [PROD_W-1:0] prod;
    logic             test, desc_new, min_hit, at_max;

    logic             acc_start, ld_init, tau_inc, eval_upd;
    logic             rep_set, rep_found;
    logic [TAU_W-1:0] rep_tau;

    assign busy    = (state_q != ST_IDLE);
    assign win_end = sample_valid_in && (wr_idx_q == LAST_IDX);
    assign go      = win_end && !busy;

    assign iss_active = (state_q == ST_SUM) && (iss_cnt_q != WI_CNT);
    assign iss_last   = (iss_cnt_q == WI_CNT - AW'(1));

    // The bank not being filled is always the one under analysis.
    assign wr_addr   = {bank_q, wr_idx_q};
    assign rd_addr_n = {~bank_q, iss_cnt_q};
    assign rd_addr_t = {~bank_q, iss_cnt_q + AW'(tau_q)};

    xilinx_true_dual_port_read_first_1_clock_ram #(
        .DATA_W(SAMPLE_W),
        .ADDR_W(AW + 1)
    ) u_ram_n (
        .clk_in (clk_in),
        .we_a   (sample_valid_in),
        .addr_a (wr_addr),
        .din_a  (sample_in),
        .dout_a (ram_n_unused),
        .we_b   (1'b0),
        .addr_b (rd_addr_n),
        .din_b  ('0),
        .dout_b (x_n)
    );

    xilinx_true_dual_port_read_first_1_clock_ram #(
        .DATA_W(SAMPLE_W),
        .ADDR_W(AW + 1)
    ) u_ram_t (
        .clk_in (clk_in),
        .we_a   (sample_valid_in),
        .addr_a (wr_addr),
        .din_a  (sample_in),
        .dout_a (ram_t_unused),
        .we_b   (1'b0),
        .addr_b (rd_addr_t),
        .din_b  ('0),
        .dout_b (x_t)
    );

    sq_diff_accumulator u_acc (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .start    (acc_start),
        .in_valid (v_d2_q),
        .in_last  (l_d2_q),
        .x_a      (x_n),
        .x_b      (x_t),
        .done     (acc_done),
        .d_sum    (d_cur)
    );

    always_comb begin
        s_new    = s_q + S_W'(d_cur);
        prod     = (PROD_W'(d_cur) * PROD_W'(tau_q)) << THRESH_SHIFT;
        test     = (tau_q >= TMIN) && !desc_q && (prod < PROD_W'(s_new));
        desc_new = desc_q || test;
        min_hit  = desc_q && (d_cur >= d_prev_q);
        at_max   = (tau_q == TMAX);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        acc_start = 1'b0;
        ld_init   = 1'b0;
        tau_inc   = 1'b0;
        eval_upd  = 1'b0;
        rep_set   = 1'b0;
        rep_found = 1'b0;
        rep_tau   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d   = ST_SUM;
                    acc_start = 1'b1;
                    ld_init   = 1'b1;
                end
            end
            ST_SUM: begin
                if (acc_done) state_d = ST_EVAL;
            end
            ST_EVAL: begin
                eval_upd = 1'b1;
                if (min_hit) begin
                    state_d   = ST_REPORT;
                    rep_set   = 1'b1;
                    rep_found = 1'b1;
                    rep_tau   = tau_q - TAU_W'(1);
                end else if (at_max) begin
                    state_d   = ST_REPORT;
                    rep_set   = 1'b1;
                    rep_found = desc_new;
                    rep_tau   = TMAX;
                end else begin
                    state_d   = ST_SUM;
                    acc_start = 1'b1;
                    tau_inc   = 1'b1;
                end
            end
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wr_idx_q  <= '0;
            bank_q    <= 1'b0;
            ovr_q     <= 1'b0;
            iss_cnt_q <= '0;
            v_d1_q    <= 1'b0;
            v_d2_q    <= 1'b0;
            l_d1_q    <= 1'b0;
            l_d2_q    <= 1'b0;
            tau_q     <= '0;
            tau_out_q <= '0;
            s_q       <= '0;
            d_prev_q  <= '0;
            desc_q    <= 1'b0;
            found_q   <= 1'b0;
        end else begin
            ovr_q <= win_end && busy;
            if (sample_valid_in) begin
                wr_idx_q <= win_end ? '0 : wr_idx_q + AW'(1);
            end
            if (go) bank_q <= ~bank_q;
            if (acc_start)       iss_cnt_q <= '0;
            else if (iss_active) iss_cnt_q <= iss_cnt_q + AW'(1);
            // Delay issue tags to line up with the two-cycle RAM read.
            v_d1_q <= iss_active;
            l_d1_q <= iss_active && iss_last;
            v_d2_q <= v_d1_q;
            l_d2_q <= l_d1_q;
            if (ld_init) begin
                tau_q    <= TAU_W'(1);
                s_q      <= '0;
                d_prev_q <= '0;
                desc_q   <= 1'b0;
            end
            if (tau_inc) tau_q <= tau_q + TAU_W'(1);
            if (eval_upd) begin
                s_q      <= s_new;
                desc_q   <= desc_new;
                d_prev_q <= d_cur;
            end
            if (rep_set) begin
                found_q <= rep_found;
                if (rep_found) tau_out_q <= rep_tau;
            end
        end
    end

    assign tau_out       = tau_out_q;
    assign tau_valid_out = (state_q == ST_REPORT) && found_q;
    assign no_pitch_out  = (state_q == ST_REPORT) && !found_q;
    assign overrun_out   = ovr_q;
    assign busy_out      = busy;

endmodule

// File: tb/tb_pitch_period_detector.sv
// Directed bench for pitch_period_detector at a reduced window size.
// Periods are scaled so each analysis stays within a few thousand cycles.
module tb_pitch_period_detector;

    localparam int WS    = 256;
    localparam int TMIN  = 20;
    localparam int TMAX  = 63;
    localparam int TSH   = 3;
    localparam int LIMIT = 20000;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic signed [15:0] sample_in;
    logic              sample_valid_in;
    logic [10:0]       tau_out;
    logic              tau_valid_out;
    logic              no_pitch_out;
    logic              overrun_out;
    logic              busy_out;

    int checks   = 0;
    int failures = 0;
    int n_valid  = 0;
    int n_nop    = 0;
    int n_ovr    = 0;
    int b_valid, b_nop, b_ovr;

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (tau_valid_out) n_valid++;
        if (no_pitch_out)  n_nop++;
        if (overrun_out)   n_ovr++;
    end

    pitch_period_detector #(
        .WINDOW_SIZE  (WS),
        .TAU_MIN      (TMIN),
        .TAU_MAX      (TMAX),
        .THRESH_SHIFT (TSH)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .sample_in       (sample_in),
        .sample_valid_in (sample_valid_in),
        .tau_out         (tau_out),
        .tau_valid_out   (tau_valid_out),
        .no_pitch_out    (no_pitch_out),
        .overrun_out     (overrun_out),
        .busy_out        (busy_out)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // kind 0: square P=40, 1: sine P=25, 2: square P=10, else zero
    function automatic logic signed [15:0] wave(input int kind, input int n);
        real ph;
        case (kind)
            0: return ((n % 40) < 20) ? 16'sd8000 : -16'sd8000;
            1: begin
                ph = 6.283185307179586 * real'(n % 25) / 25.0;
                return 16'(int'(10000.0 * $sin(ph)));
            end
            2: return ((n % 10) < 5) ? 16'sd8000 : -16'sd8000;
            default: return 16'sd0;
        endcase
    endfunction

    task automatic send_range(input int kind, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            sample_in       = wave(kind, i);
            sample_valid_in = 1'b1;
            tick();
        end
        sample_valid_in = 1'b0;
    endtask

    task automatic wait_report(input string tag);
        int cyc = 0;
        while (!(tau_valid_out || no_pitch_out) && cyc < LIMIT) begin
            tick();
            cyc++;
        end
        check({tag, "_timeout"}, 64'(cyc < LIMIT), 64'd1);
    endtask

    initial begin
        rst_in          = 1'b0;
        sample_in       = '0;
        sample_valid_in = 1'b0;
        repeat (3) tick();
        check("rst_tau_out", tau_out, 0);
        check("rst_tau_valid", tau_valid_out, 0);
        check("rst_no_pitch", no_pitch_out, 0);
        check("rst_overrun", overrun_out, 0);
        check("rst_busy", busy_out, 0);
        rst_in = 1'b1;
        tick();

        // square wave, period 40
        b_valid = n_valid;
        send_range(0, 0, WS - 1);
        check("sq40_busy_start", busy_out, 1);
        wait_report("sq40");
        check("sq40_valid", tau_valid_out, 1);
        check("sq40_no_pitch", no_pitch_out, 0);
        check("sq40_tau", tau_out, 40);
        tick();
        check("sq40_pulse_len", tau_valid_out, 0);
        check("sq40_busy_end", busy_out, 0);
        check("sq40_count", n_valid - b_valid, 1);

        // integer-period sine, period 25
        send_range(1, 0, WS - 1);
        wait_report("sin25");
        check("sin25_valid", tau_valid_out, 1);
        check("sin25_tau", tau_out, 25);
        tick();

        // square wave below TAU_MIN reports TAU_MIN multiple
        send_range(2, 0, WS - 1);
        wait_report("sq10");
        check("sq10_valid", tau_valid_out, 1);
        check("sq10_tau", tau_out, 20);
        tick();

        // silent window
        b_valid = n_valid;
        b_nop   = n_nop;
        send_range(3, 0, WS - 1);
        wait_report("zero");
        check("zero_no_pitch", no_pitch_out, 1);
        check("zero_valid", tau_valid_out, 0);
        check("zero_tau_held", tau_out, 20);
        tick();
        check("zero_pulse_len", no_pitch_out, 0);
        check("zero_nop_count", n_nop - b_nop, 1);
        check("zero_valid_count", n_valid - b_valid, 0);

        // continuous input: second window overruns
        b_valid = n_valid;
        b_nop   = n_nop;
        b_ovr   = n_ovr;
        for (int i = 0; i < 2 * WS; i++) begin
            sample_in       = wave(0, i);
            sample_valid_in = 1'b1;
            tick();
            if (i == WS - 1) begin
                check("cont_no_ovr_first", overrun_out, 0);
                check("cont_busy_first", busy_out, 1);
            end
            if (i == 2 * WS - 1) check("cont_ovr_pulse", overrun_out, 1);
        end
        sample_valid_in = 1'b0;
        tick();
        check("cont_ovr_len", overrun_out, 0);
        wait_report("cont");
        check("cont_valid", tau_valid_out, 1);
        check("cont_tau", tau_out, 40);
        repeat (500) tick();
        check("cont_idle", busy_out, 0);
        check("cont_valid_count", n_valid - b_valid, 1);
        check("cont_nop_count", n_nop - b_nop, 0);
        check("cont_ovr_count", n_ovr - b_ovr, 1);

        // one-cycle reset in the middle of SUM
        send_range(0, 0, WS - 1);
        repeat (50) tick();
        check("mid_busy_before", busy_out, 1);
        rst_in = 1'b0;
        tick();
        check("mid_rst_tau", tau_out, 0);
        check("mid_rst_busy", busy_out, 0);
        check("mid_rst_valid", tau_valid_out, 0);
        check("mid_rst_nop", no_pitch_out, 0);
        check("mid_rst_ovr", overrun_out, 0);
        rst_in  = 1'b1;
        b_valid = n_valid;
        b_nop   = n_nop;
        send_range(0, 0, 199);
        repeat (9000) tick();
        check("mid_no_report", (n_valid - b_valid) + (n_nop - b_nop), 0);
        check("mid_idle", busy_out, 0);
        send_range(0, 200, WS - 1);
        check("mid_busy_refill", busy_out, 1);
        wait_report("mid");
        check("mid_valid", tau_valid_out, 1);
        check("mid_tau", tau_out, 40);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
